// File: rtl/image_binarizer_packer.sv
// Thresholds a row-major 8-bit pixel stream to 1 bit/pixel and packs NPIX bits into one image vector.
// Latency: packed image valid 1 cycle after the final pixel is accepted; one bubble cycle per image.
// Backpressure: ready_out drops while a finished image waits in HOLD; image/valid/last stay stable until ready_in.
module image_binarizer_packer #(
  parameter int PIX_W  = 8,
  parameter int NPIX   = 324,
  parameter int THRESH = 128,
  parameter int CNT_W  = 9    // must satisfy 2**CNT_W > NPIX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             valid_in,
  input  logic             last_in,
  output logic             ready_out,
  output logic [NPIX-1:0]  image_out,
  output logic             valid_out,
  output logic             last_out,
  input  logic             ready_in,
  output logic             frame_err
);

  // FILL collects pixels; HOLD presents a complete image until downstream takes it.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [NPIX-1:0]  image_reg;
  logic             valid_reg;
  logic             last_reg;
  logic             err_reg;

  logic             accept;
  logic             at_final;
  logic             short_frame;
  logic             xfer;
  logic             pix_bit;

  assign accept      = valid_in && ready_out;
  assign at_final    = (count == CNT_W'(NPIX - 1));
  assign short_frame = accept && last_in && !at_final;
  assign xfer        = valid_reg && ready_in;
  assign pix_bit     = (pix_in >= PIX_W'(THRESH));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave FILL on the final pixel, leave HOLD on the downstream transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && at_final) state_nxt = HOLD;
      HOLD: if (xfer)               state_nxt = FILL;
      default:                      state_nxt = FILL;
    endcase
  end

  // Output decode: ready depends on registered state only, so no input reaches it.
  always_comb begin
    ready_out = 1'b0;
    case (state)
      FILL:    ready_out = 1'b1;
      HOLD:    ready_out = 1'b0;
      default: ready_out = 1'b0;
    endcase
  end

  // Pixel index: wraps to 0 after a full image or an early last_in; stalls on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (accept) begin
      if (at_final || last_in) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Packed image: each accepted pixel overwrites its own bit in place; no clear between images
  // because every bit is rewritten before the image is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      image_reg <= '0;
    end else if (accept) begin
      image_reg[count] <= pix_bit;
    end
  end

  // Output framing: valid/last rise with the final pixel and fall on the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (accept && at_final) begin
      valid_reg <= 1'b1;
      last_reg  <= last_in;
    end else if (xfer) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  // One-cycle error pulse when a frame ends early; the partial image is simply abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= short_frame;
    end
  end

  assign image_out = image_reg;
  assign valid_out = valid_reg;
  assign last_out  = last_reg;
  assign frame_err = err_reg;

endmodule

// File: doc/image_binarizer_packer.md
Name: image_binarizer_packer

Overview:
- Upstream stage of the binary-input MLP datapath.
- Accepts a row-major stream of 8-bit grayscale pixels and thresholds each pixel to 1 bit.
- Packs NPIX bits into the binary image vector consumed by the first-layer matrix multiply (bit j = pixel j).
- Presents the packed vector with valid/last framing under a ready/valid handshake, so the downstream MM stage always sees a stable operand.

Parameters:
- PIX_W, 8, width of an input pixel.
- NPIX, 324, pixels per image (18x18); also the output vector width.
- THRESH, 128, binarization threshold; bit = 1 when pixel >= THRESH (unsigned compare).
- CNT_W, 9, pixel counter width; must satisfy 2^CNT_W > NPIX.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_in  in  PIX_W  unsigned pixel.
- valid_in  in  1  pix_in is valid this cycle.
- last_in  in  1  final pixel of the final image in a batch; qualified by valid_in.
- ready_out  out  1  block accepts a pixel this cycle.
- image_out  out  NPIX  packed binary image; bit j = threshold(pixel j).
- valid_out  out  1  image_out holds a complete image.
- last_out  out  1  the image on image_out is the last of the batch.
- ready_in  in  1  downstream accepts image_out this cycle.
- frame_err  out  1  one-cycle pulse: last_in arrived before pixel NPIX-1.

Behaviour:
- Reset (async assert, sync-safe deassert): state=FILL, count=0, shift/image register=0, valid_out=0, last_out=0, frame_err=0. ready_out=1 in the first cycle after reset.
- States are FILL and HOLD. ready_out = (state==FILL), decoded combinationally from registered state only, with no path from any input.
- Pixel acceptance: an accept occurs when valid_in && ready_out at a rising edge. On accept, image_reg[count] <= (pix_in >= THRESH). The rest of image_reg holds, and count increments.
- FILL -> HOLD: on accepting pixel with count==NPIX-1:
  - Write the final bit, set count<=0, valid_out<=1, last_out<=last_in.
  - valid_out is visible in the cycle after the final pixel edge (latency 1 cycle from final pixel).
- HOLD:
  - ready_out=0, so upstream pixels are ignored and valid_in is a don't-care.
  - image_out, valid_out and last_out are held stable until the transfer.
- HOLD -> FILL: on valid_out && ready_in at an edge, set valid_out<=0 and last_out<=0. ready_out=1 in the next cycle.
  - Minimum image period is NPIX+1 cycles (one bubble per image).
- image_out is driven directly from image_reg. It is only meaningful while valid_out=1.
  - During FILL, bits of the next image overwrite in place; stale upper bits are don't-care.
  - No clearing between images is required, because every bit is rewritten before valid_out rises.
- Short frame: accept with last_in=1 and count != NPIX-1:
  - Discard the partial image: count<=0, stay in FILL, valid_out stays 0.
  - frame_err<=1 for exactly one cycle.
- last_in=0 on pixel NPIX-1: normal image with last_out=0.
- valid_in=0 cycles inside a frame stall the counter with no state change; gaps of any length are legal.
- Reset mid-frame or in HOLD: the partial or held image is dropped and all outputs return to reset values immediately (asynchronous).
- Simultaneous ready_in and a new valid_in in HOLD: only the image transfer happens; the pixel is not accepted (ready_out=0 that cycle).
- Threshold compare is unsigned, width PIX_W. Pixel 127 -> 0; pixels 128 and 255 -> 1.

Test Plan:
- Reset then stream 324 pixels, alternating 0/255 from pixel 0, ready_in=1 -> valid_out=1 one cycle after the 324th accept; image_out = 324'b10...10 (bit0=0, bit1=1); valid_out low the next cycle.
- Boundary pixels 127, 128, 255, 0 at indices 0..3, the rest 200 -> image_out[3:0]=4'b0110; bits 323:4 all 1.
- Hold ready_in=0 for 20 cycles after completion while driving valid_in=1 -> ready_out=0, image_out/valid_out unchanged; on ready_in=1 the transfer completes and the next pixel is accepted as index 0.
- last_in=1 on pixel 100 -> frame_err pulses for 1 cycle, no valid_out; the following full 324-pixel image emits normally with last_out per its own last_in.
- Two back-to-back images, the second with last_in on pixel 323, ready_in=1 throughout, random valid_in gaps -> two valid_out pulses; last_out=0 then 1; correct packed contents.
- Assert reset at pixel 200 and again during HOLD -> valid_out/last_out/frame_err=0 immediately; a subsequent full image packs from index 0.
